uart_frame_transmitter: RTL

Serializes an 11-bit UART frame (start, 8 data LSB-first, even parity, stop) onto a single TxD line at a selectable baud rate. It sits directly downstream of the frame/parity builder and consumes its `finalBitSequence[10:0]` output: bit 0 = start (0), bits 8:1 = data, bit 9 = even parity, bit 10 = stop (1). It contains its own 16x baud-tick generator and a bit-level FSM, and feeds the board UART pin or the loopback receiver.

---
 rtl/uart_frame_transmitter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_frame_transmitter.sv
// Shifts a pre-built 11-bit UART frame onto TxD, bit 0 first. Each bit lasts 16 baud ticks.
// The tick generator is a down-counter with terminal-count reload.
module uart_frame_transmitter #(
   parameter int unsigned CLK_FREQ = 50_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] frame,
   input  logic        Tx_WR,
   input  logic        Tx_EN,
   input  logic [2:0]  baud_select,
   output logic        TxD,
   output logic        Tx_BUSY,
   output logic        Tx_DONE
);

   // state | meaning
   // IDLE  | line held high, waiting for Tx_WR with Tx_EN
   // SEND  | driving shift_q[bit_idx_q], 16 ticks per bit, bits 0..10
   typedef enum logic {ST_IDLE, ST_SEND} state_t;

   localparam int unsigned DIV0 = (CLK_FREQ + 8 * 300)    / (16 * 300);
   localparam int unsigned DIV1 = (CLK_FREQ + 8 * 1200)   / (16 * 1200);
   localparam int unsigned DIV2 = (CLK_FREQ + 8 * 4800)   / (16 * 4800);
   localparam int unsigned DIV3 = (CLK_FREQ + 8 * 9600)   / (16 * 9600);
   localparam int unsigned DIV4 = (CLK_FREQ + 8 * 19200)  / (16 * 19200);
   localparam int unsigned DIV5 = (CLK_FREQ + 8 * 38400)  / (16 * 38400);
   localparam int unsigned DIV6 = (CLK_FREQ + 8 * 57600)  / (16 * 57600);
   localparam int unsigned DIV7 = (CLK_FREQ + 8 * 115200) / (16 * 115200);
   localparam int unsigned CNT_W = (DIV0 > 1) ? $clog2(DIV0) : 1;

   // Reload value is DIV-1 so that a tick fires every DIV clocks.
   function automatic logic [CNT_W-1:0] div_load(input logic [2:0] sel);
      logic [CNT_W-1:0] v;
      case (sel)
         3'd0:    v = CNT_W'(DIV0 - 1);
         3'd1:    v = CNT_W'(DIV1 - 1);
         3'd2:    v = CNT_W'(DIV2 - 1);
         3'd3:    v = CNT_W'(DIV3 - 1);
         3'd4:    v = CNT_W'(DIV4 - 1);
         3'd5:    v = CNT_W'(DIV5 - 1);
         3'd6:    v = CNT_W'(DIV6 - 1);
         default: v = CNT_W'(DIV7 - 1);
      endcase
      return v;
   endfunction

   state_t           state_q, state_d;
   logic [10:0]      shift_q, shift_d;
   logic [2:0]       baud_q, baud_d;
   logic [3:0]       bit_idx_q, bit_idx_d;
   logic [3:0]       tick_cnt_q, tick_cnt_d;
   logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
   logic             txd_q, txd_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             tick;
   logic [3:0]       next_idx;

   assign tick     = (div_cnt_q == '0);
   assign next_idx = bit_idx_q + 4'd1;

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      baud_d     = baud_q;
      bit_idx_d  = bit_idx_q;
      tick_cnt_d = tick_cnt_q;
      div_cnt_d  = div_cnt_q;
      txd_d      = txd_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            txd_d  = 1'b1;
            busy_d = 1'b0;
            if (Tx_WR && Tx_EN) begin
               state_d    = ST_SEND;
               shift_d    = frame;
               baud_d     = baud_select;
               bit_idx_d  = 4'd0;
               tick_cnt_d = 4'd0;
               div_cnt_d  = div_load(baud_select);
               txd_d      = frame[0];
               busy_d     = 1'b1;
            end
         end
         ST_SEND: begin
            if (!Tx_EN) begin
               state_d    = ST_IDLE;
               txd_d      = 1'b1;
               busy_d     = 1'b0;
               bit_idx_d  = 4'd0;
               tick_cnt_d = 4'd0;
               div_cnt_d  = '0;
            end else if (tick) begin
               div_cnt_d  = div_load(baud_q);
               tick_cnt_d = tick_cnt_q + 4'd1;
               if (tick_cnt_q == 4'd15) begin
                  if (bit_idx_q == 4'd10) begin
                     state_d    = ST_IDLE;
                     txd_d      = 1'b1;
                     busy_d     = 1'b0;
                     done_d     = 1'b1;
                     bit_idx_d  = 4'd0;
                     tick_cnt_d = 4'd0;
                     div_cnt_d  = '0;
                  end else begin
                     bit_idx_d = next_idx;
                     txd_d     = shift_q[next_idx];
                  end
               end
            end else begin
               div_cnt_d = div_cnt_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         shift_q    <= 11'h7FF;
         baud_q     <= 3'd0;
         bit_idx_q  <= 4'd0;
         tick_cnt_q <= 4'd0;
         div_cnt_q  <= '0;
         txd_q      <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         baud_q     <= baud_d;
         bit_idx_q  <= bit_idx_d;
         tick_cnt_q <= tick_cnt_d;
         div_cnt_q  <= div_cnt_d;
         txd_q      <= txd_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign TxD     = txd_q;
   assign Tx_BUSY = busy_q;
   assign Tx_DONE = done_q;

endmodule
